rob_nway: RTL and testbench
===========================

# rob_nway

N-wide reorder buffer for the R10K pipeline: accepts up to N dispatched instructions per cycle into a circular buffer. It marks entries complete by physical-tag broadcast and retires up to N completed entries per cycle in program order. Compared with the single-lane buffer, it adds parametrised width and depth, tag-matched completion, a combinational retire window and a full flush on mispredict. It sits between dispatch and the retire stage (free list / arch map update).

## Interface
- DEPTH, `PHYS_REG_SZ_R10K: number of entries; must satisfy DEPTH ≥ N; need not be a power of two.
- N, `N: superscalar width of dispatch, complete and retire.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- wr_data  in  N × ROB_ENTRY_PACKET  dispatch entries; lanes 0..num_accept-1 are meaningful, with lane 0 the oldest.
- num_accept  in  $clog2(N+1)  number of lanes dispatch wants written.
- complete_t  in  N × PHYS_IDX_W  completing physical tags.
- complete_valid  in  N  per-lane valid for complete_t.
- squash  in  1  mispredict flush.
- retiring_data  out  N × ROB_ENTRY_PACKET  head-window entries; lanes 0..num_retiring-1 are valid.
- num_retiring  out  $clog2(N+1)  entries retiring this cycle.
- open_entries  out  $clog2(DEPTH+1)  free slots as of the last edge.

## Operation
- **State:** entry array, head, tail (each 0..DEPTH-1) and count (0..DEPTH).
- **Wrap:** pointers wrap by explicit compare against DEPTH-1, not by bit truncation.
- **Dispatch:**
  - Accepted = min(num_accept, N, open_entries). Excess lanes are silently dropped.
  - Accepted lanes are written at tail, tail+1, … with valid=1.
  - The complete bit is taken from wr_data, so pre-completed NOP/halt entries are allowed.
- **Complete:**
  - Each valid complete_t lane is compared against the t field of every valid stored entry. A match sets complete=1 at the edge.
  - Unmatched tags are ignored.
  - Completion does not match entries being dispatched in the same cycle.
- **Retire window:**
  - Combinational from registered state only.
  - num_retiring = length of the contiguous run of valid & complete entries from head, capped at N and count.
  - retiring_data[i] = entry[head+i mod DEPTH] for i < num_retiring; other lanes are driven all-zero.
  - The retiring entries are removed at the edge.
- **Count update:** count_next = count − num_retiring + accepted. Accepted is computed from open_entries before retire, so slots freed this cycle are not reusable until the next cycle.
- **squash (priority over dispatch and completion):**
  - The current retire window still retires.
  - All other entries are invalidated.
  - tail is set to head_next, and count becomes 0.
  - Dispatch is ignored that cycle.
- **Tag uniqueness:** live entries carry unique t values (guaranteed by the free list). Duplicates are not checked.

## Timing
- **Reset values (next edge):**
  - head=tail=count=0 and all valid=0.
  - open_entries=DEPTH, num_retiring=0, retiring_data all-zero.
- **Dispatch:** data written at edge k is visible at head no earlier than cycle k+1.
- **Complete:** a tag broadcast in cycle k makes the entry retireable in cycle k+1, and it leaves at the end of k+1.
- **Minimum latency:** dispatch (k) → complete (k+1) → retire output (k+2).
- **open_entries:** registered-derived, so it is stable for the whole cycle.
- **Full buffer:** open_entries=0 and accepted=0. If retiring in the same cycle, the freed slots appear in open_entries at k+1.
- **Empty buffer:** num_retiring=0.
- **Same-cycle dispatch + retire + complete:** all three are legal together.
- **Reset during squash or while full:** reset wins, and the state returns to reset values.

## Structure
- **sys_defs package:**
  - ROB_ENTRY_PACKET = {valid, complete, t, t_old, dest_arch[4:0], halt}.
  - Also holds `N, `PHYS_REG_SZ_R10K and PHYS_IDX_W.
- **Sub-module rob_retire_sel:** takes the N head-window valid/complete bits and outputs the contiguous run length (num_retiring).
- **Top level:** pointers, CAM completion, write logic and squash.

## Test plan
- **Reset:** assert reset, then release → open_entries=DEPTH (32), num_retiring=0, retiring_data all-zero.
- **Dispatch and out-of-order completion:** dispatch 3 entries with t=5,6,7; complete t=6 then t=5 → num_retiring=0 after the t=6 complete. After the t=5 complete, num_retiring=2 on the next cycle with lanes t=5,6.
- **Fill, overflow and wrap:**
  - Dispatch 3/cycle until full → open_entries=0, and the next num_accept=3 is dropped.
  - Retire 3 → open_entries=3 the following cycle.
  - Further dispatch wraps tail past DEPTH-1 to 0 with correct order.
- **Clamp:** open_entries=2 with num_accept=3 → exactly 2 entries written, and open_entries=0 next cycle.
- **Squash:**
  - Head is complete with 5 younger entries; assert squash together with num_accept=3.
  - Head retires (num_retiring=1), then count=0, open_entries=DEPTH, and no dispatched entry appears.
- **Pre-complete and unmatched tag:**
  - Dispatch an entry with complete=1 → it retires at k+1.
  - Broadcast tag 40, which is not in the buffer → no state change.

Source files
------------

// File: rtl/rob_nway_pkg.sv
// Shared sizing and the entry packet for the N-wide reorder buffer.
package rob_nway_pkg;

   localparam int N_WAY            = 3;
   // ROB depth; physical tags are wider so the full physical file can be named.
   localparam int PHYS_REG_SZ_R10K = 32;
   localparam int PHYS_IDX_W       = 6;

   typedef struct packed {
      logic                  valid;
      logic                  complete;
      logic [PHYS_IDX_W-1:0] t;
      logic [PHYS_IDX_W-1:0] t_old;
      logic [4:0]            dest_arch;
      logic                  halt;
   } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_nway_if.sv
// Dispatch / complete / retire bundle between the pipeline and rob_nway.
interface rob_nway_if
   import rob_nway_pkg::*;
#(
   parameter int N     = N_WAY,
   parameter int DEPTH = PHYS_REG_SZ_R10K
) ();

   ROB_ENTRY_PACKET [N-1:0]                 wr_data;
   logic [$clog2(N+1)-1:0]                  num_accept;
   logic [N-1:0][PHYS_IDX_W-1:0]            complete_t;
   logic [N-1:0]                            complete_valid;
   logic                                    squash;
   ROB_ENTRY_PACKET [N-1:0]                 retiring_data;
   logic [$clog2(N+1)-1:0]                  num_retiring;
   logic [$clog2(DEPTH+1)-1:0]              open_entries;

   modport master (
      output wr_data, num_accept, complete_t, complete_valid, squash,
      input  retiring_data, num_retiring, open_entries
   );

   modport slave (
      input  wr_data, num_accept, complete_t, complete_valid, squash,
      output retiring_data, num_retiring, open_entries
   );

endinterface

// File: rtl/rob_nway_retire_sel.sv
// Length of the contiguous valid-and-complete run at the head of the retire window.
module rob_retire_sel
   import rob_nway_pkg::*;
#(
   parameter int N = N_WAY
) (
   input  logic [N-1:0]               valid,
   input  logic [N-1:0]               complete,
   output logic [$clog2(N+1)-1:0]     num_retiring
);

   localparam int LANE_W = $clog2(N+1);

   // Count lanes until the first one that is not ready; later lanes must wait.
   always_comb begin
      logic run_s;
      run_s        = 1'b1;
      num_retiring = '0;
      for (int i = 0; i < N; i++) begin
         run_s        = run_s & valid[i] & complete[i];
         num_retiring = num_retiring + (run_s ? LANE_W'(1) : LANE_W'(0));
      end
   end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: circular entry array with tag-matched completion,
// in-order retire of up to N entries per cycle and full flush on squash.
module rob_nway
   import rob_nway_pkg::*;
#(
   parameter int N     = N_WAY,
   parameter int DEPTH = PHYS_REG_SZ_R10K
) (
   input logic       clock,
   input logic       reset,
   rob_nway_if.slave rob
);

   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = $clog2(DEPTH+1);
   localparam int LANE_W   = $clog2(N+1);
   localparam int DEPTH_M1 = DEPTH - 1;
   localparam logic [CNT_W:0]   DEPTH_W   = DEPTH[CNT_W:0];
   localparam logic [CNT_W:0]   DEPTH_M1_W = DEPTH_M1[CNT_W:0];
   localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];
   localparam logic [CNT_W-1:0] N_CNT     = N[CNT_W-1:0];

   // Offsets never exceed DEPTH, so a single conditional subtract is enough.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx,
                                                  input logic [CNT_W-1:0] off);
      logic [CNT_W:0] sum;
      sum = {{(CNT_W+1-IDX_W){1'b0}}, idx} + {1'b0, off};
      if (sum > DEPTH_M1_W) begin
         sum = sum - DEPTH_W;
      end else begin
         sum = sum;
      end
      return sum[IDX_W-1:0];
   endfunction

   ROB_ENTRY_PACKET         entries_r   [DEPTH];
   ROB_ENTRY_PACKET         entries_n_s [DEPTH];
   logic [IDX_W-1:0]        head_r, tail_r, head_n_s, tail_n_s;
   logic [CNT_W-1:0]        count_r, count_n_s, open_r;
   logic [CNT_W-1:0]        want_s, cap_n_s, cap_s;
   logic [LANE_W-1:0]       accepted_s, num_retiring_s;
   logic [IDX_W-1:0]        win_idx_s [N];
   logic [N-1:0]            win_valid_s, win_complete_s;
   ROB_ENTRY_PACKET [N-1:0] retiring_data_s;

   // Accepted lanes: clamp the request to the width and the free slots as of the last edge.
   always_comb begin
      want_s     = CNT_W'(rob.num_accept);
      cap_n_s    = (want_s > N_CNT) ? N_CNT : want_s;
      cap_s      = (cap_n_s > open_r) ? open_r : cap_n_s;
      accepted_s = LANE_W'(cap_s);
   end

   // Retire window taken purely from registered state.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         win_idx_s[i]      = wrap_add(head_r, CNT_W'(i));
         win_valid_s[i]    = entries_r[win_idx_s[i]].valid;
         win_complete_s[i] = entries_r[win_idx_s[i]].complete;
         if (LANE_W'(i) < num_retiring_s) begin
            retiring_data_s[i] = entries_r[win_idx_s[i]];
         end else begin
            retiring_data_s[i] = '0;
         end
      end
   end

   rob_retire_sel #(.N(N)) u_retire_sel (
      .valid        (win_valid_s),
      .complete     (win_complete_s),
      .num_retiring (num_retiring_s)
   );

   // Pointer and occupancy next state; squash rewinds tail onto the post-retire head.
   always_comb begin
      head_n_s  = wrap_add(head_r, CNT_W'(num_retiring_s));
      tail_n_s  = rob.squash ? head_n_s : wrap_add(tail_r, CNT_W'(accepted_s));
      count_n_s = rob.squash ? '0
                             : count_r - CNT_W'(num_retiring_s) + CNT_W'(accepted_s);
   end

   // Entry next state: CAM completion, retire, flush, then dispatch into free slots.
   always_comb begin
      entries_n_s = entries_r;
      for (int e = 0; e < DEPTH; e++) begin
         for (int l = 0; l < N; l++) begin
            entries_n_s[e].complete = entries_n_s[e].complete |
               (rob.complete_valid[l] & entries_r[e].valid &
                (entries_r[e].t == rob.complete_t[l]));
         end
      end
      for (int i = 0; i < N; i++) begin
         entries_n_s[win_idx_s[i]].valid = entries_n_s[win_idx_s[i]].valid &
                                           ~(LANE_W'(i) < num_retiring_s);
      end
      for (int e = 0; e < DEPTH; e++) begin
         entries_n_s[e].valid = entries_n_s[e].valid & ~rob.squash;
      end
      for (int i = 0; i < N; i++) begin
         if (!rob.squash && (LANE_W'(i) < accepted_s)) begin
            entries_n_s[wrap_add(tail_r, CNT_W'(i))]       = rob.wr_data[i];
            entries_n_s[wrap_add(tail_r, CNT_W'(i))].valid = 1'b1;
         end else begin
            entries_n_s[wrap_add(tail_r, CNT_W'(i))] = entries_n_s[wrap_add(tail_r, CNT_W'(i))];
         end
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
         open_r  <= DEPTH_CNT;
         for (int e = 0; e < DEPTH; e++) begin
            entries_r[e] <= '0;
         end
      end else begin
         head_r    <= head_n_s;
         tail_r    <= tail_n_s;
         count_r   <= count_n_s;
         open_r    <= DEPTH_CNT - count_n_s;
         entries_r <= entries_n_s;
      end
   end

   assign rob.retiring_data = retiring_data_s;
   assign rob.num_retiring  = num_retiring_s;
   assign rob.open_entries  = open_r;

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway (N=3, DEPTH=32) with hand-computed expectations.
module tb_rob_nway;
   import rob_nway_pkg::*;

   localparam int N     = 3;
   localparam int DEPTH = 32;

   logic clock;
   logic reset;
   int   compared;
   int   mismatched;

   rob_nway_if #(.N(N), .DEPTH(DEPTH)) bus ();

   rob_nway #(.N(N), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .rob   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic ROB_ENTRY_PACKET mk(input logic [5:0] t, input logic c, input logic h);
      ROB_ENTRY_PACKET p;
      p           = '0;
      p.t         = t;
      p.complete  = c;
      p.t_old     = t ^ 6'h20;
      p.dest_arch = t[4:0];
      p.halt      = h;
      return p;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.wr_data        = '0;
      bus.num_accept     = 2'd0;
      bus.complete_t     = '0;
      bus.complete_valid = 3'b000;
      bus.squash         = 1'b0;
   endtask

   task automatic set_dispatch(input int n, input int t0, input int t1, input int t2, input logic c);
      bus.num_accept = 2'(n);
      bus.wr_data[0] = mk(6'(t0), c, 1'b0);
      bus.wr_data[1] = mk(6'(t1), c, 1'b0);
      bus.wr_data[2] = mk(6'(t2), c, 1'b0);
   endtask

   task automatic set_complete(input logic [2:0] mask, input int t0, input int t1, input int t2);
      bus.complete_valid = mask;
      bus.complete_t[0]  = 6'(t0);
      bus.complete_t[1]  = 6'(t1);
      bus.complete_t[2]  = 6'(t2);
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      compared++;
      if (bus.open_entries !== 6'd32) begin
         mismatched++; $display("FAIL reset_open actual=%0d required=32", bus.open_entries);
      end
      compared++;
      if (bus.num_retiring !== 2'd0) begin
         mismatched++; $display("FAIL reset_num_retiring actual=%0d required=0", bus.num_retiring);
      end
      compared++;
      if (bus.retiring_data !== '0) begin
         mismatched++; $display("FAIL reset_retiring_data actual=%h required=0", bus.retiring_data);
      end
   endtask

   task automatic test_ooo_complete();
      set_dispatch(3, 5, 6, 7, 1'b0);
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd29) begin
         mismatched++; $display("FAIL ooo_open actual=%0d required=29", bus.open_entries);
      end
      set_complete(3'b001, 6, 0, 0);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd0) begin
         mismatched++; $display("FAIL ooo_blocked actual=%0d required=0", bus.num_retiring);
      end
      set_complete(3'b010, 0, 5, 0);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd2 || bus.retiring_data[0].t !== 6'd5 ||
          bus.retiring_data[1].t !== 6'd6 || bus.retiring_data[2] !== '0) begin
         mismatched++; $display("FAIL ooo_retire2 actual n=%0d t=%0d,%0d lane2=%h required n=2 t=5,6 lane2=0",
                                bus.num_retiring, bus.retiring_data[0].t, bus.retiring_data[1].t, bus.retiring_data[2]);
      end
      tick();
      compared++;
      if (bus.open_entries !== 6'd31 || bus.num_retiring !== 2'd0) begin
         mismatched++; $display("FAIL ooo_after actual open=%0d n=%0d required open=31 n=0",
                                bus.open_entries, bus.num_retiring);
      end
      set_complete(3'b100, 0, 0, 7);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd1 || bus.retiring_data[0].t !== 6'd7) begin
         mismatched++; $display("FAIL ooo_last actual n=%0d t=%0d required n=1 t=7",
                                bus.num_retiring, bus.retiring_data[0].t);
      end
      tick();
      compared++;
      if (bus.open_entries !== 6'd32) begin
         mismatched++; $display("FAIL ooo_empty actual=%0d required=32", bus.open_entries);
      end
   endtask

   task automatic test_fill_wrap();
      int order [32];
      int base;
      int prev_b;
      int b;
      logic ok;
      for (int c = 0; c < 10; c++) begin
         set_dispatch(3, 3*c, 3*c+1, 3*c+2, 1'b0);
         tick();
      end
      idle();
      compared++;
      if (bus.open_entries !== 6'd2) begin
         mismatched++; $display("FAIL clamp_pre actual=%0d required=2", bus.open_entries);
      end
      set_dispatch(3, 30, 31, 32, 1'b0);
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd0) begin
         mismatched++; $display("FAIL clamp_full actual=%0d required=0", bus.open_entries);
      end
      set_dispatch(3, 50, 51, 52, 1'b1);
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd0 || bus.num_retiring !== 2'd0) begin
         mismatched++; $display("FAIL overflow_drop actual open=%0d n=%0d required open=0 n=0",
                                bus.open_entries, bus.num_retiring);
      end
      set_complete(3'b111, 0, 1, 2);
      tick(); idle();
      set_dispatch(3, 53, 54, 55, 1'b0);
      compared++;
      if (bus.num_retiring !== 2'd3 || bus.retiring_data[0].t !== 6'd0 ||
          bus.retiring_data[1].t !== 6'd1 || bus.retiring_data[2].t !== 6'd2) begin
         mismatched++; $display("FAIL full_retire actual n=%0d t=%0d,%0d,%0d required n=3 t=0,1,2",
                                bus.num_retiring, bus.retiring_data[0].t, bus.retiring_data[1].t, bus.retiring_data[2].t);
      end
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd3) begin
         mismatched++; $display("FAIL freed_slots actual=%0d required=3", bus.open_entries);
      end
      set_dispatch(3, 60, 61, 62, 1'b0);
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd0) begin
         mismatched++; $display("FAIL refill actual=%0d required=0", bus.open_entries);
      end
      for (int i = 0; i < 29; i++) order[i] = i + 3;
      order[29] = 60; order[30] = 61; order[31] = 62;
      base   = 0;
      prev_b = 0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin
            ok = (bus.num_retiring === 2'(prev_b));
            for (int l = 0; l < 3; l++) begin
               if (l < prev_b) ok = ok && (bus.retiring_data[l].t === 6'(order[base-prev_b+l]));
               else            ok = ok && (bus.retiring_data[l] === '0);
            end
            compared++;
            if (!ok) begin
               mismatched++; $display("FAIL wrap_order cyc=%0d actual n=%0d t=%0d,%0d,%0d required n=%0d first_t=%0d",
                                      c, bus.num_retiring, bus.retiring_data[0].t, bus.retiring_data[1].t,
                                      bus.retiring_data[2].t, prev_b, order[base-prev_b]);
            end
         end
         b = (32 - base >= 3) ? 3 : 32 - base;
         idle();
         for (int l = 0; l < b; l++) begin
            bus.complete_valid[l] = 1'b1;
            bus.complete_t[l]     = 6'(order[base+l]);
         end
         base   = base + b;
         prev_b = b;
         tick();
      end
      idle();
      compared++;
      if (bus.open_entries !== 6'd32) begin
         mismatched++; $display("FAIL drain_empty actual=%0d required=32", bus.open_entries);
      end
   endtask

   task automatic test_squash();
      set_dispatch(3, 1, 2, 3, 1'b0);
      tick(); idle();
      set_dispatch(3, 4, 5, 6, 1'b0);
      set_complete(3'b001, 1, 0, 0);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd1 || bus.retiring_data[0].t !== 6'd1) begin
         mismatched++; $display("FAIL squash_head actual n=%0d t=%0d required n=1 t=1",
                                bus.num_retiring, bus.retiring_data[0].t);
      end
      bus.squash = 1'b1;
      set_dispatch(3, 7, 8, 9, 1'b1);
      set_complete(3'b001, 2, 0, 0);
      tick(); idle();
      compared++;
      if (bus.open_entries !== 6'd32 || bus.num_retiring !== 2'd0) begin
         mismatched++; $display("FAIL squash_flush actual open=%0d n=%0d required open=32 n=0",
                                bus.open_entries, bus.num_retiring);
      end
      tick();
      compared++;
      if (bus.num_retiring !== 2'd0 || bus.retiring_data !== '0) begin
         mismatched++; $display("FAIL squash_nodispatch actual n=%0d data=%h required n=0 data=0",
                                bus.num_retiring, bus.retiring_data);
      end
   endtask

   task automatic test_precomplete_unmatched();
      ROB_ENTRY_PACKET exp_e;
      exp_e       = mk(6'd20, 1'b1, 1'b1);
      exp_e.valid = 1'b1;
      bus.num_accept = 2'd1;
      bus.wr_data[0] = mk(6'd20, 1'b1, 1'b1);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd1 || bus.retiring_data[0] !== exp_e) begin
         mismatched++; $display("FAIL precomplete actual n=%0d e=%h required n=1 e=%h",
                                bus.num_retiring, bus.retiring_data[0], exp_e);
      end
      tick();
      bus.num_accept = 2'd1;
      bus.wr_data[0] = mk(6'd21, 1'b0, 1'b0);
      tick(); idle();
      set_complete(3'b100, 0, 0, 40);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd0 || bus.open_entries !== 6'd31) begin
         mismatched++; $display("FAIL unmatched_tag actual n=%0d open=%0d required n=0 open=31",
                                bus.num_retiring, bus.open_entries);
      end
      set_complete(3'b010, 0, 21, 0);
      tick(); idle();
      compared++;
      if (bus.num_retiring !== 2'd1 || bus.retiring_data[0].t !== 6'd21) begin
         mismatched++; $display("FAIL matched_tag actual n=%0d t=%0d required n=1 t=21",
                                bus.num_retiring, bus.retiring_data[0].t);
      end
      tick();
      compared++;
      if (bus.open_entries !== 6'd32) begin
         mismatched++; $display("FAIL tag_empty actual=%0d required=32", bus.open_entries);
      end
   endtask

   task automatic test_reset_while_full();
      for (int c = 0; c < 11; c++) begin
         set_dispatch(3, 3*c, 3*c+1, 3*c+2, 1'b0);
         tick();
      end
      idle();
      compared++;
      if (bus.open_entries !== 6'd0) begin
         mismatched++; $display("FAIL full_before_reset actual=%0d required=0", bus.open_entries);
      end
      set_complete(3'b111, 0, 1, 2);
      bus.squash = 1'b1;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      compared++;
      if (bus.open_entries !== 6'd32 || bus.num_retiring !== 2'd0 || bus.retiring_data !== '0) begin
         mismatched++; $display("FAIL reset_full actual open=%0d n=%0d required open=32 n=0",
                                bus.open_entries, bus.num_retiring);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      idle();
      test_reset();
      test_ooo_complete();
      test_fill_wrap();
      test_squash();
      test_precomplete_unmatched();
      test_reset_while_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
